stream_conv_engine: RTL and testbench

- Parametrised streaming 2-D convolution core. Successor to the fixed Conv block.
- Accepts a channel-interleaved raster pixel stream (row, then column, then channel) one sample per cycle over a valid/ready handshake.
- Produces one full-depth dot product (summed over K_DIM×K_DIM×IMG_CH) per output position.
- Adds over the previous generation: configurable stride, signed mode, output backpressure, per-frame weight capture and back-to-back frame streaming.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_out_fifo.sv | 54 +++++
 rtl/stream_conv_engine.sv | 150 +++++++++++++++
 tb/tb_stream_conv_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, typedefs and index helpers for the streaming convolution engine.
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WGT_W_DEF  = 8;
  localparam int K_DIM_DEF  = 2;
  localparam int IMG_CH_DEF = 3;

  function automatic int acc_width(input int dw, input int ww, input int kd, input int ch);
    return dw + ww + $clog2(kd * kd * ch);
  endfunction

  // Flat kernel layout: tap (i, j, k) lives at ((i*K_DIM + j)*IMG_CH + k).
  function automatic int wgt_idx(input int i, input int j, input int k, input int kd, input int ch);
    return (i * kd + j) * ch + k;
  endfunction

  localparam int ACC_W_DEF = acc_width(DATA_W_DEF, WGT_W_DEF, K_DIM_DEF, IMG_CH_DEF);

  typedef logic [DATA_W_DEF-1:0] pix_t;
  typedef logic [WGT_W_DEF-1:0]  wgt_t;
  typedef logic [ACC_W_DEF-1:0]  acc_t;

endpackage

// File: rtl/conv_out_fifo.sv
// Two-entry result FIFO; push and pop on a full FIFO in one cycle keeps the count.
module conv_out_fifo
  import conv_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/stream_conv_engine.sv
// Streaming 2-D convolution: K_DIM-row line buffer, single-cycle full-depth MAC,
// one MAC pipeline register and a 2-entry output FIFO with backpressure.
module stream_conv_engine
  import conv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int WGT_W   = 8,
  parameter int K_DIM   = 2,
  parameter int IMG_DIM = 4,
  parameter int IMG_CH  = 3,
  parameter int STRIDE  = 1,
  parameter int SIGNED  = 0,
  parameter int ACC_W   = acc_width(DATA_W, WGT_W, K_DIM, IMG_CH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_W-1:0]                 in_pix,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [K_DIM*K_DIM*IMG_CH*WGT_W-1:0] weights,
  output logic [ACC_W-1:0]                  out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              frame_done
);

  localparam int NTAP     = K_DIM * K_DIM * IMG_CH;
  localparam int OUT_DIM  = (IMG_DIM - K_DIM) / STRIDE + 1;
  localparam int LAST_POS = (OUT_DIM - 1) * STRIDE + K_DIM - 1;
  localparam int PW       = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam int CW       = (IMG_CH > 1) ? $clog2(IMG_CH) : 1;
  localparam int LB_N     = K_DIM * IMG_DIM * IMG_CH;
  localparam int LBAW     = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic [CW-1:0]        ch_q, ch_d;
  logic [PW-1:0]        col_q, col_d, row_q, row_d;
  logic                 run_q;
  logic [DATA_W-1:0]    lb_q [LB_N];
  logic [NTAP*WGT_W-1:0] wgt_q, wgt_sel;
  logic [ACC_W-1:0]     mac_d, mac_p0_q;
  logic                 vld_p0_q, last_p0_q, frame_done_q;
  logic [1:0]           fifo_cnt;
  logic                 xfer, first_pix, fire, last_win;
  logic [LBAW-1:0]      wr_addr;
  logic [DATA_W-1:0]    mpx;
  logic [WGT_W-1:0]     mwv;

  function automatic logic [ACC_W-1:0] ext_pix(input logic [DATA_W-1:0] v);
    return (SIGNED != 0) ? {{(ACC_W-DATA_W){v[DATA_W-1]}}, v} : {{(ACC_W-DATA_W){1'b0}}, v};
  endfunction

  function automatic logic [ACC_W-1:0] ext_wgt(input logic [WGT_W-1:0] v);
    return (SIGNED != 0) ? {{(ACC_W-WGT_W){v[WGT_W-1]}}, v} : {{(ACC_W-WGT_W){1'b0}}, v};
  endfunction

  // At most two results may be in flight, so an accepted fire always finds FIFO room.
  assign in_ready  = run_q && ((int'(fifo_cnt) + int'(vld_p0_q)) < 2);
  assign xfer      = in_valid && in_ready;
  assign first_pix = (ch_q == '0) && (col_q == '0) && (row_q == '0);
  assign fire      = (int'(ch_q) == IMG_CH - 1)
                  && (int'(row_q) >= K_DIM - 1) && (int'(col_q) >= K_DIM - 1)
                  && (((int'(row_q) - K_DIM + 1) % STRIDE) == 0)
                  && (((int'(col_q) - K_DIM + 1) % STRIDE) == 0);
  assign last_win  = (int'(row_q) == LAST_POS) && (int'(col_q) == LAST_POS);
  assign wr_addr   = LBAW'(((int'(row_q) % K_DIM) * IMG_DIM + int'(col_q)) * IMG_CH + int'(ch_q));
  assign wgt_sel   = first_pix ? weights : wgt_q;

  always_comb begin
    ch_d  = ch_q;
    col_d = col_q;
    row_d = row_q;
    if (xfer) begin
      if (int'(ch_q) == IMG_CH - 1) begin
        ch_d = '0;
        if (int'(col_q) == IMG_DIM - 1) begin
          col_d = '0;
          row_d = (int'(row_q) == IMG_DIM - 1) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
  end

  // The newest sample of the window is still on in_pix; all others are in the line buffer.
  always_comb begin
    mac_d = '0;
    mpx   = '0;
    mwv   = '0;
    for (int i = 0; i < K_DIM; i++) begin
      for (int j = 0; j < K_DIM; j++) begin
        for (int k = 0; k < IMG_CH; k++) begin
          if (i == K_DIM - 1 && j == K_DIM - 1 && k == IMG_CH - 1) begin
            mpx = in_pix;
          end else begin
            mpx = lb_q[LBAW'(((((int'(row_q) + 1 + i) % K_DIM) * IMG_DIM)
                   + ((int'(col_q) - K_DIM + 1 + j + IMG_DIM) % IMG_DIM)) * IMG_CH + k)];
          end
          mwv   = wgt_sel[wgt_idx(i, j, k, K_DIM, IMG_CH)*WGT_W +: WGT_W];
          mac_d = mac_d + ext_pix(mpx) * ext_wgt(mwv);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q        <= 1'b0;
      ch_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      vld_p0_q     <= 1'b0;
      last_p0_q    <= 1'b0;
      mac_p0_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      ch_q         <= ch_d;
      col_q        <= col_d;
      row_q        <= row_d;
      // ---- stage p0: MAC result registered, pushed into the FIFO on the next edge ----
      vld_p0_q     <= xfer && fire;
      last_p0_q    <= xfer && fire && last_win;
      if (xfer && fire) mac_p0_q <= mac_d;
      frame_done_q <= vld_p0_q && last_p0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) lb_q[wr_addr] <= in_pix;
    if (xfer && first_pix) wgt_q <= weights;
  end

  // ---- stage p1: result FIFO ----
  conv_out_fifo #(.W(ACC_W)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (vld_p0_q),
    .data_i  (mac_p0_q),
    .pop_i   (out_valid && out_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
    .count_o (fifo_cnt)
  );

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_stream_conv_engine.sv
// Bench for stream_conv_engine: default, STRIDE=2 and SIGNED=1 instances against a window-sum model.
module tb_stream_conv_engine;

  localparam int K = 2, N = 4, C = 3;
  localparam int NT = K * K * C;
  localparam int AW = 8 + 8 + $clog2(NT);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]      in_pix;
  logic [NT*8-1:0] weights;
  logic            out_ready;
  logic            iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2, fd0, fd1, fd2;
  logic [AW-1:0]   od0, od1, od2;

  stream_conv_engine u_dut (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(iv0), .in_ready(ir0), .weights(weights),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .frame_done(fd0));
  stream_conv_engine #(.STRIDE(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(iv1), .in_ready(ir1), .weights(weights),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .frame_done(fd1));
  stream_conv_engine #(.SIGNED(1)) u_dut_sg (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(iv2), .in_ready(ir2), .weights(weights),
    .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .frame_done(fd2));

  int            cur;
  logic          m_ir, m_ov, m_fd;
  logic [AW-1:0] m_od;

  always_comb begin
    m_ir = ir0; m_ov = ov0; m_fd = fd0; m_od = od0;
    if (cur == 1) begin m_ir = ir1; m_ov = ov1; m_fd = fd1; m_od = od1; end
    if (cur == 2) begin m_ir = ir2; m_ov = ov2; m_fd = fd2; m_od = od2; end
  end

  int n_chk = 0, n_pass = 0;
  int stim[$];
  int got[$];
  int exp_q[$];
  int fd_cnt, fd_at, hold_bad, stall_seen;
  logic [AW-1:0] hold_prev;
  bit hold_prev_v;
  int wk_def[NT], wk_one[NT], wk_ff[NT], wk_a[NT], wk_b[NT];

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (m_ov && out_ready) got.push_back(int'(m_od));
      if (m_fd) begin fd_cnt++; fd_at = got.size(); end
      if (m_ov && !out_ready) begin
        if (hold_prev_v && (m_od != hold_prev)) hold_bad++;
        hold_prev   = m_od;
        hold_prev_v = 1'b1;
      end else begin
        hold_prev_v = 1'b0;
      end
      if (!m_ir && !out_ready) stall_seen = 1;
    end
  end

  task automatic set_valid(input bit b);
    iv0 = (cur == 0) && b;
    iv1 = (cur == 1) && b;
    iv2 = (cur == 2) && b;
  endtask

  function automatic logic [NT*8-1:0] pack(input int wk[NT]);
    logic [NT*8-1:0] r;
    for (int t = 0; t < NT; t++) r[t*8 +: 8] = 8'(wk[t]);
    return r;
  endfunction

  task automatic clear_sb();
    got.delete(); exp_q.delete();
    fd_cnt = 0; fd_at = 0; hold_bad = 0; stall_seen = 0;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge of the last transfer.
  task automatic drive(input int gap_at, input int gap_len, input bit rnd_gap,
                       input int chg_at, input logic [NT*8-1:0] w_next);
    int  tries;
    bit  acc;
    for (int idx = 0; idx < stim.size(); idx++) begin
      if (idx == gap_at || (rnd_gap && $urandom_range(0, 3) == 0)) begin
        set_valid(1'b0);
        repeat ((idx == gap_at) ? gap_len : 1) begin @(posedge clk); #1; end
      end
      in_pix = 8'(stim[idx]);
      set_valid(1'b1);
      tries = 0;
      forever begin
        @(negedge clk); acc = m_ir;
        @(posedge clk); #1;
        if (acc) break;
        tries++;
        if (tries > 200) begin
          check("in_ready_timeout", 0, 1);
          set_valid(1'b0);
          return;
        end
      end
      if (idx == chg_at) weights = w_next;
    end
    set_valid(1'b0);
  endtask

  // Reference: each output is the plain window sum over rows, columns and channels.
  task automatic model_frame(input int base, input int stride, input bit sgn, input int wk[NT]);
    int od, p, w;
    longint acc;
    od = (N - K) / stride + 1;
    for (int oy = 0; oy < od; oy++)
      for (int ox = 0; ox < od; ox++) begin
        acc = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            for (int k = 0; k < C; k++) begin
              p = stim[base + ((oy*stride + i)*N + ox*stride + j)*C + k];
              w = wk[(i*K + j)*C + k];
              if (sgn) begin
                if (p >= 128) p -= 256;
                if (w >= 128) w -= 256;
              end
              acc += longint'(p) * longint'(w);
            end
        exp_q.push_back(int'(acc & ((longint'(1) << AW) - 1)));
      end
  endtask

  task automatic wait_outputs(input int n);
    for (int c = 0; c < 400 && got.size() < n; c++) @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_out%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic ramp_frame(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(i);
  endtask

  initial begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        for (int k = 0; k < C; k++) begin
          wk_def[(i*K + j)*C + k] = i + j + k;
          wk_one[(i*K + j)*C + k] = 1;
          wk_ff[(i*K + j)*C + k]  = 255;
          wk_a[(i*K + j)*C + k]   = int'($urandom_range(0, 255));
          wk_b[(i*K + j)*C + k]   = int'($urandom_range(0, 255));
        end
    cur = 0; rst = 1'b0; out_ready = 1'b1; in_pix = '0; weights = '0;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    clear_sb();

    repeat (3) @(negedge clk);
    check("rst_in_ready", m_ir, 0);
    check("rst_out_valid", m_ov, 0);
    check("rst_out_data", m_od, 0);
    check("rst_frame_done", m_fd, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", m_ir, 1);

    // Defaults, ramp pixels, 5-cycle gap mid-frame
    clear_sb(); ramp_frame(48); weights = pack(wk_def);
    drive(24, 5, 1'b0, -1, '0);
    model_frame(0, 1, 1'b0, wk_def);
    wait_outputs(9);
    compare("dflt");
    check("dflt_first", got.size() > 0 ? got[0] : -1, 257);
    check("dflt_second", got.size() > 1 ? got[1] : -1, 329);
    check("dflt_third", got.size() > 2 ? got[2] : -1, 401);
    check("dflt_fourth", got.size() > 3 ? got[3] : -1, 545);
    check("dflt_fd_cnt", fd_cnt, 1);
    check("dflt_fd_at", fd_at, 9);

    // Output backpressure for 20 cycles
    clear_sb(); ramp_frame(48); weights = pack(wk_def);
    fork
      drive(-1, 0, 1'b0, -1, '0);
      begin
        repeat (14) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    model_frame(0, 1, 1'b0, wk_def);
    wait_outputs(9);
    compare("bp");
    check("bp_in_ready_drop", stall_seen, 1);
    check("bp_hold_changes", hold_bad, 0);
    check("bp_fd_cnt", fd_cnt, 1);

    // Back-to-back frames, weights changed after frame-1 pixel 0
    clear_sb(); ramp_frame(48); weights = pack(wk_def);
    for (int i = 0; i < 48; i++) stim.push_back(255);
    drive(-1, 0, 1'b0, 0, pack(wk_one));
    model_frame(0, 1, 1'b0, wk_def);
    model_frame(48, 1, 1'b0, wk_one);
    wait_outputs(18);
    compare("b2b");
    check("b2b_f2_val", got.size() > 9 ? got[9] : -1, 3060);
    check("b2b_fd_cnt", fd_cnt, 2);

    // Random pixels/weights, random gaps, two frames with weight switch
    clear_sb(); stim.delete();
    for (int i = 0; i < 96; i++) stim.push_back(int'($urandom_range(0, 255)));
    weights = pack(wk_a);
    drive(-1, 0, 1'b1, 0, pack(wk_b));
    model_frame(0, 1, 1'b0, wk_a);
    model_frame(48, 1, 1'b0, wk_b);
    wait_outputs(18);
    compare("rnd");

    // STRIDE=2 instance
    cur = 1;
    clear_sb(); ramp_frame(48); weights = pack(wk_def);
    drive(24, 5, 1'b0, -1, '0);
    model_frame(0, 2, 1'b0, wk_def);
    wait_outputs(4);
    compare("s2");
    check("s2_out2_const", got.size() > 2 ? got[2] : -1, 833);
    check("s2_out3_const", got.size() > 3 ? got[3] : -1, 977);
    check("s2_fd_at", fd_at, 4);

    // SIGNED=1 instance
    cur = 2;
    clear_sb(); stim.delete();
    for (int i = 0; i < 48; i++) stim.push_back(128);
    weights = pack(wk_ff);
    drive(-1, 0, 1'b0, -1, '0);
    model_frame(0, 1, 1'b1, wk_ff);
    wait_outputs(9);
    compare("sg");
    check("sg_const", got.size() > 0 ? got[0] : -1, 1536);
    clear_sb(); stim.delete();
    for (int i = 0; i < 48; i++) stim.push_back(int'($urandom_range(0, 255)));
    weights = pack(wk_a);
    drive(-1, 0, 1'b1, -1, '0);
    model_frame(0, 1, 1'b1, wk_a);
    wait_outputs(9);
    compare("sg_rnd");

    // Reset after 20 samples, then a fresh frame
    cur = 0;
    clear_sb(); ramp_frame(20); weights = pack(wk_def);
    drive(-1, 0, 1'b0, -1, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", m_ov, 0);
    check("mid_rst_in_ready", m_ir, 0);
    check("mid_rst_out_data", m_od, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    clear_sb(); ramp_frame(48);
    drive(-1, 0, 1'b0, -1, '0);
    model_frame(0, 1, 1'b0, wk_def);
    wait_outputs(9);
    compare("post_rst");
    check("post_rst_first", got.size() > 0 ? got[0] : -1, 257);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
